pc_unit_ras: RTL
================

PC_UNIT_RAS -- requirements
Module: pc_unit_ras

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: width of the address, offset and target datapath.
REQ-002 SHALL have parameter RAS_DEPTH, default 4: number of entries in the return-address stack (RAS); legal values are 2 to 16.
REQ-003 SHALL have parameter RESET_ADDR, default 0: value loaded into the PC on reset.
REQ-004 SHALL have port clock, input, 1: single clock; all state updates on its falling edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port stall, input, 1: hold the PC and the RAS.
REQ-007 SHALL have port write_condition, input, 1: condition passed; qualifies the branch.
REQ-008 SHALL have port should_branch, input, 1: branch instruction present.
REQ-009 SHALL have port branch_mode, input, 2: 00 relative, 01 absolute, 10 call, 11 return.
REQ-010 SHALL have port branch_value, input, ADDR_W: signed two's-complement offset.
REQ-011 SHALL have port link_value, input, ADDR_W: absolute target; also the fallback target for a return.
REQ-012 SHALL have port instruction_address, output, ADDR_W: current PC (registered).
REQ-013 SHALL have port link_address, output, ADDR_W: top-of-RAS entry; 0 when the RAS is empty.
REQ-014 SHALL have port ras_count, output, $clog2(RAS_DEPTH+1): number of valid RAS entries.
REQ-015 SHALL have port ras_overflow, output, 1: one-cycle pulse when a call is made while the RAS is full.
REQ-016 SHALL have port ras_underflow, output, 1: one-cycle pulse when a return is made while the RAS is empty.

Function
REQ-017 SHALL define taken = should_branch & write_condition & ~stall, and seq = instruction_address + 1.
REQ-018 SHALL, when not taken and not stalled, load instruction_address <= seq.
REQ-019 SHALL, when taken with relative mode (00), load seq + branch_value, computed modulo 2^ADDR_W with carry discarded.
REQ-020 SHALL, when taken with absolute mode (01), load link_value.
REQ-021 SHALL, when taken with call mode (10), load seq + branch_value and push seq onto the RAS in the same edge.
REQ-022 SHALL, when taken with return mode (11) and ras_count>0, load the top entry and pop it.
REQ-023 SHALL, for a return with ras_count==0, load link_value, leave ras_count at 0 and pulse ras_underflow.
REQ-024 SHALL, for a push with ras_count==RAS_DEPTH, overwrite the oldest entry (circular), keep ras_count at RAS_DEPTH and pulse ras_overflow.
REQ-025 SHALL, while stall=1, hold instruction_address, all RAS contents and ras_count, and drive both flag outputs to 0.
REQ-026 SHALL ignore branch_mode whenever taken is 0; the RAS is unchanged in that case.
REQ-027 SHALL let instruction_address wrap from 2^ADDR_W-1 to 0 on a sequential advance.
REQ-028 SHALL update link_address and ras_count on the same edge as the push or pop that changes them (latency 0 cycles after the edge).
REQ-029 SHALL deassert ras_overflow and ras_underflow on the next edge unless the condition recurs.

Reset
REQ-030 SHALL, on reset=1 at a falling edge, set instruction_address=RESET_ADDR, ras_count=0, link_address=0 and both flags to 0.
REQ-031 SHALL give reset priority over stall and over a taken branch, including a call or return in flight; no push or pop occurs.
REQ-032 SHALL NOT require RAS storage contents to be cleared on reset; entries are invalid by ras_count alone.

Structure
REQ-033 SHALL take the branch_mode encodings (BR_REL, BR_ABS, BR_CALL, BR_RET) from the shared package pc_pkg.
REQ-034 SHALL implement the RAS as one sub-module ras_lifo (parameters DEPTH and W) with push/pop/top/count/full/empty ports.
REQ-035 SHALL keep the next-PC selection combinational in pc_unit_ras and all state in registers clocked by the falling edge.

Verification
REQ-036 SHALL cover: reset, then 3 edges with no branch -> instruction_address 0,1,2,3.
REQ-037 SHALL cover: PC=10, relative branch with branch_value=-5 (all ones minus 4) -> PC=6; with write_condition=0 -> PC=11.
REQ-038 SHALL cover: PC=20, call with offset 100 -> PC=121, link_address=21, ras_count=1; then return -> PC=21, ras_count=0.
REQ-039 SHALL cover: RAS_DEPTH=4, five nested calls -> ras_overflow pulses on the 5th; five returns -> first four pop the newest four addresses, 5th falls back to link_value with ras_underflow pulsed.
REQ-040 SHALL cover: stall=1 during a call -> PC, ras_count and link_address unchanged; reset asserted during a return with ras_count=2 -> PC=RESET_ADDR, ras_count=0.
REQ-041 SHALL cover: ADDR_W=8, PC=255, sequential advance -> PC=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: branch mode encodings.
package pc_pkg;
  typedef enum logic [1:0] {
    BR_REL  = 2'b00,
    BR_ABS  = 2'b01,
    BR_CALL = 2'b10,
    BR_RET  = 2'b11
  } br_mode_e;
endpackage

// File: rtl/ras_lifo.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module ras_lifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               push_data,
  output logic [W-1:0]               top,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           wr_ptr, top_ptr, nxt_ptr;

  // wr_ptr is the next free slot; top sits one below, modulo DEPTH
  assign top_ptr = (wr_ptr == '0) ? PW'(DEPTH-1) : wr_ptr - PW'(1);
  assign nxt_ptr = (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + PW'(1);

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign top   = empty ? '0 : mem[top_ptr];

  always_ff @(negedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      mem[wr_ptr] <= push_data;
      wr_ptr      <= nxt_ptr;
      if (!full) count <= count + CW'(1);
    end else if (pop && !empty) begin
      wr_ptr <= top_ptr;
      count  <= count - CW'(1);
    end
  end
endmodule

// File: rtl/pc_unit_ras.sv
// Program counter with relative/absolute/call/return branching backed by a RAS.
module pc_unit_ras
  import pc_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                RAS_DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           stall,
  input  logic                           write_condition,
  input  logic                           should_branch,
  input  logic [1:0]                     branch_mode,
  input  logic [ADDR_W-1:0]              branch_value,
  input  logic [ADDR_W-1:0]              link_value,
  output logic [ADDR_W-1:0]              instruction_address,
  output logic [ADDR_W-1:0]              link_address,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_overflow,
  output logic                           ras_underflow
);
  logic              taken, push, pop, ovf_set, unf_set, ovf_q, unf_q;
  logic              ras_full, ras_empty;
  logic [ADDR_W-1:0] seq, pc_next;

  assign taken = should_branch & write_condition & ~stall;
  assign seq   = instruction_address + ADDR_W'(1);

  always_comb begin
    pc_next = seq;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (taken) begin
      case (br_mode_e'(branch_mode))
        BR_REL:  pc_next = seq + branch_value;
        BR_ABS:  pc_next = link_value;
        BR_CALL: begin
          pc_next = seq + branch_value;
          push    = 1'b1;
          ovf_set = ras_full;
        end
        BR_RET: begin
          if (!ras_empty) begin
            pc_next = link_address;
            pop     = 1'b1;
          end else begin
            pc_next = link_value;
            unf_set = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(negedge clock) begin
    if (reset) begin
      instruction_address <= RESET_ADDR;
      ovf_q               <= 1'b0;
      unf_q               <= 1'b0;
    end else begin
      if (!stall) instruction_address <= pc_next;
      ovf_q <= ovf_set;
      unf_q <= unf_set;
    end
  end

  // Flags are forced low for the whole stalled cycle, not just from the next edge
  assign ras_overflow  = ovf_q & ~stall;
  assign ras_underflow = unf_q & ~stall;

  ras_lifo #(.DEPTH(RAS_DEPTH), .W(ADDR_W)) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (push & ~reset),
    .pop       (pop & ~reset),
    .push_data (seq),
    .top       (link_address),
    .count     (ras_count),
    .full      (ras_full),
    .empty     (ras_empty)
  );
endmodule
